// File: rtl/matrix_op_engine.sv
// matrix_op_engine: element-wise multiply/add execution core.
// Pops operand pairs from the A/B FIFOs, computes A*B (shift-add, 32 cycles)
// or A+B (1 cycle), stores results in a small buffer read combinationally.
module matrix_op_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              multi_op_start,
  input  logic              adder_op_start,
  input  logic              op_clear,
  input  logic [DATA_W-1:0] fifo0_dout,
  input  logic [CNT_W-1:0]  fifo0_count,
  output logic              fifo0_re,
  input  logic [DATA_W-1:0] fifo1_dout,
  input  logic [CNT_W-1:0]  fifo1_count,
  output logic              fifo1_re,
  input  logic [AW-1:0]     rAddr,
  output logic [DATA_W-1:0] result,
  output logic              adder_op_done,
  output logic              busy,
  output logic [AW:0]       elem_cnt
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LATCH, S_MUL, S_EXEC, S_WRITE, S_DONE
  } state_t;

  state_t            state_q;
  logic              op_mul_q;
  logic [AW:0]       cnt_q;
  logic              done_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] buf_q [DEPTH];

  logic start_any;
  logic can_pop;
  logic pop;

  assign start_any = multi_op_start | adder_op_start;
  // An element is processed only while both sides have data and the buffer has room.
  assign can_pop   = (fifo0_count != '0) && (fifo1_count != '0) && (cnt_q != DEPTH_C);
  // The pop lives only in CHECK; a concurrent clear must leave the FIFOs untouched.
  assign pop       = (state_q == S_CHECK) && can_pop && !op_clear;

  assign fifo0_re      = pop;
  assign fifo1_re      = pop;
  assign adder_op_done = done_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign elem_cnt      = cnt_q;
  assign result        = buf_q[rAddr];

  // Control FSM with operand latch, shift-add multiplier and adder datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_mul_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      bit_q    <= '0;
    end else if (op_clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_any) begin
            op_mul_q <= multi_op_start;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            state_q  <= S_CHECK;
          end
        end
        S_DONE: begin
          if (start_any) begin
            op_mul_q <= multi_op_start;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            state_q  <= S_CHECK;
          end else begin
            done_q <= 1'b1;
          end
        end
        S_CHECK: begin
          state_q <= can_pop ? S_LATCH : S_DONE;
        end
        S_LATCH: begin
          mcand_q  <= fifo0_dout;
          mplier_q <= fifo1_dout;
          acc_q    <= '0;
          bit_q    <= '0;
          state_q  <= op_mul_q ? S_MUL : S_EXEC;
        end
        S_MUL: begin
          // One multiplier bit per cycle; bits shifted past DATA_W drop out (mod 2^DATA_W).
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          bit_q    <= bit_q + BW'(1);
          if (bit_q == BIT_LAST) state_q <= S_WRITE;
        end
        S_EXEC: begin
          acc_q   <= mcand_q + mplier_q;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          cnt_q   <= cnt_q + (AW+1)'(1);
          state_q <= S_CHECK;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result buffer: cleared by reset/op_clear, one entry written per element in WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (op_clear) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (state_q == S_WRITE) begin
      buf_q[cnt_q[AW-1:0]] <= acc_q;
    end
  end

endmodule

// File: tb/tb_matrix_op_engine.sv
// Testbench for matrix_op_engine: bench-side FIFO model, table vectors,
// randomized operations against a reference model, and hand-written corner cases.
`timescale 1ns/100ps
module tb_matrix_op_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        multi_op_start, adder_op_start, op_clear;
  logic [31:0] fifo0_dout, fifo1_dout;
  logic [3:0]  fifo0_count, fifo1_count;
  logic        fifo0_re, fifo1_re;
  logic [2:0]  rAddr;
  logic [31:0] result;
  logic        adder_op_done, busy;
  logic [3:0]  elem_cnt;

  matrix_op_engine dut (
    .clk(clk), .reset(reset),
    .multi_op_start(multi_op_start), .adder_op_start(adder_op_start), .op_clear(op_clear),
    .fifo0_dout(fifo0_dout), .fifo0_count(fifo0_count), .fifo0_re(fifo0_re),
    .fifo1_dout(fifo1_dout), .fifo1_count(fifo1_count), .fifo1_re(fifo1_re),
    .rAddr(rAddr), .result(result),
    .adder_op_done(adder_op_done), .busy(busy), .elem_cnt(elem_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mul;
    int na;
    int nb;
    int exp_cnt;
    int exp_lat;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          pops0 = 0;
  int          pops1 = 0;
  logic [31:0] av[8];
  logic [31:0] bv[8];
  int          na, nb;
  logic [31:0] exp_buf[8];
  vec_t        tbl[8];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the FIFO model honours pops seen before the edge.
  task automatic tick();
    logic r0, r1;
    r0 = fifo0_re;
    r1 = fifo1_re;
    @(posedge clk);
    #1;
    if (r0) begin
      pops0++;
      chk("pop0_nonempty", longint'(q0.size() > 0), 1);
      if (q0.size() > 0) fifo0_dout = q0.pop_front();
    end
    if (r1) begin
      pops1++;
      chk("pop1_nonempty", longint'(q1.size() > 0), 1);
      if (q1.size() > 0) fifo1_dout = q1.pop_front();
    end
    fifo0_count = 4'(q0.size());
    fifo1_count = 4'(q1.size());
  endtask

  task automatic load_fifos();
    q0.delete();
    q1.delete();
    for (int i = 0; i < na; i++) q0.push_back(av[i]);
    for (int i = 0; i < nb; i++) q1.push_back(bv[i]);
    fifo0_count = 4'(q0.size());
    fifo1_count = 4'(q1.size());
    tick();
    tick();
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 8; i++) begin
      rAddr = 3'(i);
      #1;
      chk($sformatf("%s_buf%0d", tag, i), result, exp_buf[i]);
    end
  endtask

  function automatic int model_n(input int a, input int b);
    int n;
    n = (a < b) ? a : b;
    if (n > 8) n = 8;
    return n;
  endfunction

  // Runs one operation from freshly loaded FIFOs and checks everything observable.
  task automatic do_op(input bit mul, input bit both, input int inj, input int extra_at,
                       input int exp_cnt, input int exp_lat, input string tag);
    int n, lat, p0, p1, extra;
    logic [63:0] prod;
    load_fifos();
    n = model_n(na, nb);
    for (int i = 0; i < n; i++) begin
      if (mul) begin
        prod = 64'(av[i]) * 64'(bv[i]);
        exp_buf[i] = prod[31:0];
      end else begin
        exp_buf[i] = av[i] + bv[i];
      end
    end
    p0 = pops0;
    p1 = pops1;
    extra = 0;
    multi_op_start = mul | both;
    adder_op_start = !mul | both;
    tick();
    multi_op_start = 1'b0;
    adder_op_start = 1'b0;
    chk({tag, "_done_cleared"}, adder_op_done, 0);
    lat = -1;
    for (int k = 1; k <= 2000 && lat < 0; k++) begin
      if (k == inj) multi_op_start = 1'b1;
      if (k == extra_at) begin
        q0.push_back(32'h55);
        q1.push_back(32'haa);
        extra = 1;
      end
      tick();
      multi_op_start = 1'b0;
      if (k == 1) chk({tag, "_busy_early"}, busy, longint'(n > 0));
      if (adder_op_done) lat = k;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_elem_cnt"}, elem_cnt, exp_cnt);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_pops0"}, pops0 - p0, n);
    chk({tag, "_pops1"}, pops1 - p1, n);
    chk({tag, "_left0"}, q0.size(), na - n + extra);
    chk({tag, "_left1"}, q1.size(), nb - n + extra);
    check_buf(tag);
  endtask

  initial begin
    tbl[0] = '{mul: 1'b0, na: 3, nb: 3, exp_cnt: 3, exp_lat: 14};
    tbl[1] = '{mul: 1'b1, na: 2, nb: 2, exp_cnt: 2, exp_lat: 72};
    tbl[2] = '{mul: 1'b0, na: 8, nb: 8, exp_cnt: 8, exp_lat: 34};
    tbl[3] = '{mul: 1'b1, na: 5, nb: 2, exp_cnt: 2, exp_lat: 72};
    tbl[4] = '{mul: 1'b1, na: 5, nb: 0, exp_cnt: 0, exp_lat: 2};
    tbl[5] = '{mul: 1'b0, na: 0, nb: 4, exp_cnt: 0, exp_lat: 2};
    tbl[6] = '{mul: 1'b1, na: 1, nb: 1, exp_cnt: 1, exp_lat: 37};
    tbl[7] = '{mul: 1'b0, na: 6, nb: 7, exp_cnt: 6, exp_lat: 26};

    reset = 1'b1;
    multi_op_start = 1'b0;
    adder_op_start = 1'b0;
    op_clear = 1'b0;
    fifo0_dout = '0;
    fifo1_dout = '0;
    fifo0_count = '0;
    fifo1_count = '0;
    rAddr = '0;
    for (int i = 0; i < 8; i++) exp_buf[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_done", adder_op_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_elem_cnt", elem_cnt, 0);
    chk("rst_re0", fifo0_re, 0);
    chk("rst_re1", fifo1_re, 0);
    check_buf("rst");

    // Basic add of three pairs
    na = 3; nb = 3;
    av[0] = 1; av[1] = 2; av[2] = 3;
    bv[0] = 4; bv[1] = 5; bv[2] = 6;
    do_op(1'b0, 1'b0, 0, 0, 3, 14, "add3");
    chk("add3_lit0", exp_buf[0], 5);
    chk("add3_lit2", exp_buf[2], 9);

    // Multiply with wrap of the upper product bits
    na = 2; nb = 2;
    av[0] = 3; av[1] = 32'hFFFF_FFFF;
    bv[0] = 7; bv[1] = 2;
    do_op(1'b1, 1'b0, 0, 0, 2, 72, "mul2");
    rAddr = 3'd1;
    #1;
    chk("mul2_raddr1", result, 32'hFFFF_FFFE);
    rAddr = 3'd0;
    #1;
    chk("mul2_raddr0", result, 21);

    // Full buffer of wrapping adds; extra data pushed mid-op must stay in the FIFOs
    na = 8; nb = 8;
    for (int i = 0; i < 8; i++) begin
      av[i] = 32'hFFFF_FFFF;
      bv[i] = 32'd1;
    end
    do_op(1'b0, 1'b0, 0, 10, 8, 34, "wrap8");
    rAddr = 3'd7;
    #1;
    chk("wrap8_raddr7", result, 0);

    // Table vectors with random operand data
    for (int t = 0; t < 8; t++) begin
      na = tbl[t].na;
      nb = tbl[t].nb;
      for (int i = 0; i < 8; i++) begin
        av[i] = $urandom;
        bv[i] = $urandom;
      end
      do_op(tbl[t].mul, 1'b0, 0, 0, tbl[t].exp_cnt, tbl[t].exp_lat, $sformatf("tbl%0d", t));
    end

    // Fully random operations checked against the model
    for (int t = 0; t < 6; t++) begin
      int n;
      bit m;
      m  = 1'($urandom_range(0, 1));
      na = $urandom_range(0, 8);
      nb = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) begin
        av[i] = (t % 2 == 0) ? $urandom : 32'($urandom_range(0, 15));
        bv[i] = $urandom;
      end
      n = model_n(na, nb);
      do_op(m, 1'b0, 0, 0, n, 2 + n * (m ? 35 : 4), $sformatf("rnd%0d", t));
    end

    // op_clear in the middle of a multiply, with an ignored start during MUL
    na = 1; nb = 1;
    av[0] = 5; bv[0] = 6;
    load_fifos();
    multi_op_start = 1'b1;
    tick();
    multi_op_start = 1'b0;
    repeat (2) tick();
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) multi_op_start = 1'b1;
      tick();
      multi_op_start = 1'b0;
    end
    chk("clr_busy_before", busy, 1);
    op_clear = 1'b1;
    adder_op_start = 1'b1;
    tick();
    op_clear = 1'b0;
    adder_op_start = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_done", adder_op_done, 0);
    chk("clr_elem_cnt", elem_cnt, 0);
    for (int i = 0; i < 8; i++) exp_buf[i] = '0;
    check_buf("clr");
    repeat (3) tick();
    chk("clr_start_ignored", busy, 0);
    chk("clr_no_pop", fifo0_re, 0);

    // Start pulse during MUL is ignored
    na = 1; nb = 1;
    av[0] = 4; bv[0] = 5;
    do_op(1'b1, 1'b0, 10, 0, 1, 37, "mulinj");

    // Both starts together run a multiply
    na = 1; nb = 1;
    av[0] = 3; bv[0] = 7;
    do_op(1'b1, 1'b1, 0, 0, 1, 37, "both");
    chk("both_lit", exp_buf[0], 21);

    // Reset asserted during LATCH
    na = 1; nb = 1;
    av[0] = 9; bv[0] = 9;
    load_fifos();
    adder_op_start = 1'b1;
    tick();
    adder_op_start = 1'b0;
    tick();
    chk("latch_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mrst_re0", fifo0_re, 0);
    chk("mrst_re1", fifo1_re, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", adder_op_done, 0);
    chk("mrst_elem_cnt", elem_cnt, 0);
    for (int i = 0; i < 8; i++) exp_buf[i] = '0;
    check_buf("mrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    na = 1; nb = 1;
    av[0] = 1; bv[0] = 2;
    do_op(1'b0, 1'b0, 0, 0, 1, 6, "post_rst");
    chk("post_rst_lit", exp_buf[0], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
